reaction_stats: RTL and testbench
=================================

REACTION_STATS -- requirements
Module: reaction_stats

Interface
Parameters:
REQ-001 The block SHALL have parameter CLIP, default 14'd9999, which is the maximum reaction time stored or displayed, in ms.
REQ-002 The block SHALL have parameter NONE, default 14'h3FFF, which is the sentinel value of best_time meaning "no valid attempt yet".

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: system clock (the tick_ms domain clock).
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port result_valid, input, 1 bit: one-cycle pulse; result_time is valid this cycle.
REQ-006 The block SHALL have port result_time, input, 14 bits: measured reaction time in ms (unsigned).
REQ-007 The block SHALL have port false_start, input, 1 bit: one-cycle pulse; the attempt was aborted (button pressed before lights out).
REQ-008 The block SHALL have port mode_btn, input, 1 bit: display-mode button, active-high level, already synchronous to clk.
REQ-009 The block SHALL have port disp_value, output, 14 bits: value selected for the bin2bcd/7-seg path.
REQ-010 The block SHALL have port disp_mode, output, 2 bits: current display mode (0 last, 1 best, 2 average, 3 counts).
REQ-011 The block SHALL have port best_time, output, 14 bits: lowest valid time recorded, or NONE.
REQ-012 The block SHALL have port attempt_count, output, 4 bits: number of valid attempts, saturating at 15.
REQ-013 The block SHALL have port false_count, output, 4 bits: number of false starts, saturating at 15.
REQ-014 The block SHALL have port new_best, output, 1 bit: one-cycle pulse when a valid attempt beats best_time.

Function
REQ-015 On a valid attempt (result_valid=1 and false_start=0), the block SHALL capture t = min(result_time, CLIP).
REQ-016 When false_start=1 and result_valid=1 arrive in the same cycle, false_start SHALL win: false_count increments (saturating) and result_time is discarded.
REQ-017 A valid attempt SHALL update last_time to t, registered, visible on the cycle after result_valid.
REQ-018 The history SHALL be a 4-entry ring buffer with a 2-bit write pointer.
  - Each valid attempt writes t at the pointer and then advances the pointer, wrapping 3->0.
  - A fill counter (0..4) tracks occupancy and saturates at 4.
REQ-019 A 16-bit running sum SHALL track the buffer contents.
  - Each write adds t; when fill==4 it also subtracts the overwritten entry.
  - Add and subtract occur in the same cycle.
  - The sum never exceeds 4*CLIP, so it does not overflow.
REQ-020 The average SHALL be sum>>2 (truncating) when fill==4, and 0 otherwise.
  - The average is valid on the cycle after the fourth and each later valid attempt.
REQ-021 A valid attempt with t < best_time (strict) SHALL set best_time to t and pulse new_best for exactly one cycle, the cycle after result_valid.
  - If t equals best_time, neither best_time nor new_best changes.
REQ-022 A valid attempt SHALL increment attempt_count, saturating at 15.
  - Saturation does not stop buffer, sum or best updates.
REQ-023 The mode state machine SHALL have states LAST(0), BEST(1), AVG(2) and CNT(3).
  - Each mode_btn rising edge (mode_btn=1 with previous-cycle sample 0) advances the state, wrapping CNT->LAST.
  - A held button advances the state once only.
REQ-024 disp_value SHALL be selected as follows:
  - LAST: last_time.
  - BEST: best_time, or 0 when best_time==NONE.
  - AVG: average.
  - CNT: attempt_count*100 + false_count, e.g. 3 attempts and 2 false starts gives 302.
  - disp_value is registered, one cycle after any change of mode or data.
REQ-025 disp_mode SHALL equal the current state.
REQ-026 result_valid and mode-button events in the same cycle SHALL both be processed independently.

Reset
REQ-027 Asserting rst at any time, including mid-update, SHALL asynchronously clear the block:
  - Buffer, sum, fill, pointer, last_time, attempt_count, false_count, new_best, disp_value: all 0.
  - Mode state: LAST.
  - best_time: NONE.
  - Edge-detect register: 0.
REQ-028 After rst deasserts, the first clk edge SHALL process inputs normally, and no spurious mode advance SHALL occur if mode_btn is already high.

Verification
REQ-029 Reset check: after rst, verify best_time=0x3FFF, disp_mode=0, disp_value=0, and all counts 0.
REQ-030 Attempt sequence: valid attempts 250, 300, 200, 350, then mode=AVG -> average=275, best_time=200, new_best pulses after 250 and after 200 only.
REQ-031 Ring wrap: continue REQ-030 with a fifth attempt of 150 -> sum=1000, AVG=250, best_time=150, attempt_count=5.
REQ-032 Clipping and conflict:
  - result_time=12000 -> last_time=9999.
  - Simultaneous result_valid and false_start -> false_count+1, last_time unchanged.
REQ-033 Mode and saturation:
  - Holding mode_btn for 10 cycles advances the mode once.
  - Four presses return the mode to LAST.
  - 20 valid attempts -> attempt_count=15; in CNT mode, disp_value=1500+false_count.
REQ-034 Reset mid-operation: assert rst one cycle after result_valid with fill=3 -> all state is cleared, and the next 4 attempts give an average over those 4 only.

Source files
------------

// File: rtl/reaction_stats.sv
// Reaction-timer statistics: last/best/average-of-4 tracking, attempt and
// false-start counters, and a button-cycled display-value selector.
module reaction_stats #(
   parameter logic [13:0] CLIP = 14'd9999,
   parameter logic [13:0] NONE = 14'h3FFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        result_valid,
   input  logic [13:0] result_time,
   input  logic        false_start,
   input  logic        mode_btn,
   output logic [13:0] disp_value,
   output logic [1:0]  disp_mode,
   output logic [13:0] best_time,
   output logic [3:0]  attempt_count,
   output logic [3:0]  false_count,
   output logic        new_best
);

   typedef enum logic [1:0] {
      StLast = 2'd0,
      StBest = 2'd1,
      StAvg  = 2'd2,
      StCnt  = 2'd3
   } mode_e;

   mode_e       mode_q, mode_d;
   logic        btn_prev_q, btn_prev_d;
   logic        armed_q, armed_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [2:0]  fill_q, fill_d;
   logic [15:0] sum_q, sum_d;
   logic [13:0] ring_q [4];
   logic [13:0] ring_d [4];
   logic [13:0] last_q, last_d;
   logic [13:0] best_q, best_d;
   logic [3:0]  att_q, att_d;
   logic [3:0]  false_q, false_d;
   logic        new_best_q, new_best_d;
   logic [13:0] disp_q, disp_d;

   logic        valid_att;
   logic        btn_rise;
   logic [13:0] t_clip;
   logic [13:0] avg_val;
   logic [13:0] cnt_val;

   // Decode the incoming attempt; a false start overrides a coincident result.
   always_comb begin
      valid_att = result_valid & ~false_start;
      t_clip    = (result_time > CLIP) ? CLIP : result_time;
   end

   // Next-state for history ring, running sum, best time and counters.
   always_comb begin
      ptr_d      = ptr_q;
      fill_d     = fill_q;
      sum_d      = sum_q;
      ring_d     = ring_q;
      last_d     = last_q;
      best_d     = best_q;
      att_d      = att_q;
      false_d    = false_q;
      new_best_d = 1'b0;
      if (false_start) begin
         if (false_q != 4'd15) false_d = false_q + 4'd1;
      end else if (result_valid) begin
         last_d         = t_clip;
         ring_d[ptr_q]  = t_clip;
         ptr_d          = ptr_q + 2'd1;
         // Once full, the entry being overwritten leaves the sum in the same cycle.
         if (fill_q == 3'd4) begin
            sum_d = sum_q + 16'(t_clip) - 16'(ring_q[ptr_q]);
         end else begin
            sum_d  = sum_q + 16'(t_clip);
            fill_d = fill_q + 3'd1;
         end
         if (att_q != 4'd15) att_d = att_q + 4'd1;
         if (t_clip < best_q) begin
            best_d     = t_clip;
            new_best_d = 1'b1;
         end
      end
   end

   // Mode FSM: advance on a button rising edge; the first cycle after reset
   // only samples the button so a held button cannot cause an advance.
   always_comb begin
      mode_d     = mode_q;
      btn_prev_d = mode_btn;
      armed_d    = 1'b1;
      btn_rise   = armed_q & mode_btn & ~btn_prev_q;
      if (btn_rise) begin
         unique case (mode_q)
            StLast:  mode_d = StBest;
            StBest:  mode_d = StAvg;
            StAvg:   mode_d = StCnt;
            StCnt:   mode_d = StLast;
            default: mode_d = StLast;
         endcase
      end
   end

   // Display value selection from the current mode and registered data.
   always_comb begin
      avg_val = (fill_q == 3'd4) ? sum_q[15:2] : 14'd0;
      cnt_val = 14'(att_q) * 14'd100 + 14'(false_q);
      disp_d  = 14'd0;
      unique case (mode_q)
         StLast:  disp_d = last_q;
         StBest:  disp_d = (best_q == NONE) ? 14'd0 : best_q;
         StAvg:   disp_d = avg_val;
         StCnt:   disp_d = cnt_val;
         default: disp_d = 14'd0;
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= StLast;
         btn_prev_q <= 1'b0;
         armed_q    <= 1'b0;
         ptr_q      <= 2'd0;
         fill_q     <= 3'd0;
         sum_q      <= 16'd0;
         for (int i = 0; i < 4; i++) ring_q[i] <= 14'd0;
         last_q     <= 14'd0;
         best_q     <= NONE;
         att_q      <= 4'd0;
         false_q    <= 4'd0;
         new_best_q <= 1'b0;
         disp_q     <= 14'd0;
      end else begin
         mode_q     <= mode_d;
         btn_prev_q <= btn_prev_d;
         armed_q    <= armed_d;
         ptr_q      <= ptr_d;
         fill_q     <= fill_d;
         sum_q      <= sum_d;
         for (int i = 0; i < 4; i++) ring_q[i] <= ring_d[i];
         last_q     <= last_d;
         best_q     <= best_d;
         att_q      <= att_d;
         false_q    <= false_d;
         new_best_q <= new_best_d;
         disp_q     <= disp_d;
      end
   end

   // Output mapping.
   always_comb begin
      disp_value    = disp_q;
      disp_mode     = mode_q;
      best_time     = best_q;
      attempt_count = att_q;
      false_count   = false_q;
      new_best      = new_best_q;
   end

endmodule

// File: tb/tb_reaction_stats.sv
// Scoreboard bench for reaction_stats: stimulus queues expected values,
// a monitor pops and compares them at the scheduled sample cycle.
module tb_reaction_stats;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        result_valid = 1'b0;
   logic [13:0] result_time = 14'd0;
   logic        false_start = 1'b0;
   logic        mode_btn = 1'b0;
   logic [13:0] disp_value;
   logic [1:0]  disp_mode;
   logic [13:0] best_time;
   logic [3:0]  attempt_count;
   logic [3:0]  false_count;
   logic        new_best;

   reaction_stats dut (
      .clk           (clk),
      .rst           (rst),
      .result_valid  (result_valid),
      .result_time   (result_time),
      .false_start   (false_start),
      .mode_btn      (mode_btn),
      .disp_value    (disp_value),
      .disp_mode     (disp_mode),
      .best_time     (best_time),
      .attempt_count (attempt_count),
      .false_count   (false_count),
      .new_best      (new_best)
   );

   always #5 clk = ~clk;

   localparam int SelDisp  = 0;
   localparam int SelMode  = 1;
   localparam int SelBest  = 2;
   localparam int SelAtt   = 3;
   localparam int SelFalse = 4;

   typedef struct {
      int    cyc;
      int    sel;
      int    exp;
      string name;
   } exp_t;

   exp_t scb[$];
   int   nbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int get_val(input int sel);
      case (sel)
         SelDisp:  return int'(disp_value);
         SelMode:  return int'(disp_mode);
         SelBest:  return int'(best_time);
         SelAtt:   return int'(attempt_count);
         SelFalse: return int'(false_count);
         default:  return -1;
      endcase
   endfunction

   // Monitor: sample #1 after each rising edge.
   initial begin
      exp_t e;
      int   act;
      bit   exp_nb;
      forever begin
         @(posedge clk);
         #1;
         while (scb.size() > 0 && scb[0].cyc <= cyc) begin
            e = scb.pop_front();
            act = get_val(e.sel);
            checks++;
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL %s: sampled late at cycle %0d, scheduled %0d", e.name, cyc, e.cyc);
            end else if (act != e.exp) begin
               errors++;
               $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.exp, cyc);
            end
         end
         exp_nb = (nbq.size() > 0 && nbq[0] == cyc);
         if (exp_nb) void'(nbq.pop_front());
         if (exp_nb || new_best) begin
            checks++;
            if (new_best !== exp_nb) begin
               errors++;
               $display("FAIL new_best: got %0b expected %0b (cycle %0d)", new_best, exp_nb, cyc);
            end
         end
         while (nbq.size() > 0 && nbq[0] < cyc) begin
            void'(nbq.pop_front());
            errors++;
            $display("FAIL new_best: pulse missing, got 0 expected 1");
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input int sel, input int exp, input string name);
      scb.push_back('{cyc + 1, sel, exp, name});
   endtask

   task automatic attempt(input int tm, input bit fs, input bit nb);
      @(negedge clk);
      result_valid = 1'b1;
      result_time  = 14'(tm);
      false_start  = fs;
      if (nb) nbq.push_back(cyc + 1);
      @(negedge clk);
      result_valid = 1'b0;
      false_start  = 1'b0;
   endtask

   task automatic press();
      @(negedge clk);
      mode_btn = 1'b1;
      @(negedge clk);
      mode_btn = 1'b0;
   endtask

   initial begin
      // Reset state
      idle(3);
      rst = 1'b0;
      chk(SelBest, 16'h3FFF, "rst_best");
      chk(SelMode, 0, "rst_mode");
      chk(SelDisp, 0, "rst_disp");
      chk(SelAtt, 0, "rst_att");
      chk(SelFalse, 0, "rst_false");
      idle(1);

      // Four attempts, then AVG
      attempt(250, 0, 1);
      attempt(300, 0, 0);
      attempt(200, 0, 1);
      attempt(350, 0, 0);
      idle(1);
      chk(SelDisp, 350, "last_350");
      chk(SelBest, 200, "best_200");
      chk(SelAtt, 4, "att_4");
      idle(1);
      press();
      press();
      idle(1);
      chk(SelMode, 2, "mode_avg");
      chk(SelDisp, 275, "avg_275");
      idle(1);

      // Ring wrap
      attempt(150, 0, 1);
      idle(1);
      chk(SelDisp, 250, "avg_wrap_250");
      chk(SelBest, 150, "best_150");
      chk(SelAtt, 5, "att_5");
      idle(1);
      press();
      idle(1);
      chk(SelMode, 3, "mode_cnt");
      chk(SelDisp, 500, "cnt_500");
      idle(1);

      // Held button advances once (CNT -> LAST)
      @(negedge clk);
      mode_btn = 1'b1;
      idle(10);
      mode_btn = 1'b0;
      idle(1);
      chk(SelMode, 0, "hold_once");
      chk(SelDisp, 150, "last_150");
      idle(1);

      // Clipping and conflict
      attempt(12000, 0, 0);
      idle(1);
      chk(SelDisp, 9999, "clip_9999");
      idle(1);
      attempt(100, 1, 0);
      idle(1);
      chk(SelFalse, 1, "conflict_false");
      chk(SelDisp, 9999, "conflict_last");
      chk(SelBest, 150, "conflict_best");
      chk(SelAtt, 6, "conflict_att");
      idle(1);

      // Four presses return to LAST
      press();
      idle(1);
      chk(SelMode, 1, "mode_best");
      chk(SelDisp, 150, "disp_best_150");
      idle(1);
      press();
      press();
      press();
      idle(1);
      chk(SelMode, 0, "four_press_last");
      idle(1);

      // Saturation
      for (int i = 0; i < 14; i++) attempt(500, 0, 0);
      press();
      press();
      press();
      idle(1);
      chk(SelAtt, 15, "att_sat");
      chk(SelMode, 3, "mode_cnt_sat");
      chk(SelDisp, 1501, "cnt_1501");
      idle(1);

      // Reset mid-operation with fill=3
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      attempt(100, 0, 1);
      attempt(200, 0, 0);
      attempt(300, 0, 0);
      #2 rst = 1'b1;
      idle(2);
      mode_btn = 1'b1;
      rst = 1'b0;
      chk(SelBest, 16'h3FFF, "mrst_best");
      chk(SelAtt, 0, "mrst_att");
      chk(SelFalse, 0, "mrst_false");
      chk(SelDisp, 0, "mrst_disp");
      idle(3);
      chk(SelMode, 0, "no_spurious_adv");
      idle(1);
      mode_btn = 1'b0;
      press();
      idle(1);
      chk(SelMode, 1, "mrst_mode_best");
      chk(SelDisp, 0, "best_none_0");
      idle(1);
      attempt(401, 0, 1);
      attempt(300, 0, 1);
      attempt(200, 0, 1);
      attempt(100, 0, 1);
      idle(1);
      chk(SelDisp, 100, "mrst_best_100");
      idle(1);
      press();
      idle(1);
      chk(SelDisp, 250, "mrst_avg_250");
      chk(SelAtt, 4, "mrst_att_4");
      idle(3);

      if (scb.size() > 0 || nbq.size() > 0) begin
         errors += scb.size() + nbq.size();
         $display("FAIL leftover: got %0d pending expected 0", scb.size() + nbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
